// File: rtl/if_fetch.sv
// Instruction fetch front end: owns the PC, issues in-order imem fetches, queues responses for ID and discards wrong-path data after a redirect.
// A response accepted at an edge is visible to ID one cycle later. Hold freezes the head, and the credit limit stops new requests.
module if_fetch #(
  parameter int                ADDR_W       = 32,
  parameter int                INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter int                MAX_OUTST    = 2,
  parameter int                HOLD_W       = 3,
  parameter logic [HOLD_W-1:0] HOLD_CODE_ID = HOLD_W'(1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               jmp_en_i,
  input  logic [ADDR_W-1:0]  jmp_to_i,
  input  logic [HOLD_W-1:0]  hold_code_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [CW-1:0]      r_outst;
  logic [CW-1:0]      r_drop;
  logic [CW-1:0]      r_out_cnt;
  logic [PW-1:0]      r_tag_wr, r_tag_rd;
  logic [PW-1:0]      r_out_wr, r_out_rd;
  logic [ADDR_W-1:0]  r_tag     [MAX_OUTST];
  logic [ADDR_W-1:0]  r_out_pc  [MAX_OUTST];
  logic [INSTR_W-1:0] r_out_ins [MAX_OUTST];

  logic              w_hold, w_redirect, w_credit, w_grant;
  logic              w_rsp, w_keep, w_push, w_pop;
  logic [CW:0]       w_used;
  logic [ADDR_W-1:0] w_jmp_tgt;

  assign w_hold     = (hold_code_i == HOLD_CODE_ID);
  assign w_redirect = jmp_en_i && !w_hold;
  assign w_jmp_tgt  = jmp_to_i & ~ADDR_W'(3);

  // Credits cover both in-flight (including to-be-dropped) and buffered entries, so the FIFO can never overflow.
  assign w_used     = {1'b0, r_outst} + {1'b0, r_out_cnt};
  assign w_credit   = w_used < (CW+1)'(MAX_OUTST);

  assign imem_req_o  = !rst && w_credit && !w_redirect;
  assign imem_addr_o = r_fetch_pc;
  assign w_grant     = imem_req_o && imem_gnt_i;

  // A response with nothing outstanding is a leftover from before reset.
  assign w_rsp  = imem_rvalid_i && (r_outst != '0);
  assign w_keep = w_rsp && (r_drop == '0);
  assign w_push = w_keep && !w_redirect;
  assign w_pop  = (r_out_cnt != '0) && !w_hold;

  assign instr_valid_o = (r_out_cnt != '0);
  assign instr_o       = instr_valid_o ? r_out_ins[r_out_rd] : '0;
  assign pc_o          = instr_valid_o ? r_out_pc[r_out_rd]  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_drop     <= '0;
      r_out_cnt  <= '0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
      r_out_wr   <= '0;
      r_out_rd   <= '0;
    end else begin
      if (w_grant && !w_rsp)
        r_outst <= r_outst + CW'(1);
      else if (!w_grant && w_rsp)
        r_outst <= r_outst - CW'(1);

      if (w_redirect)
        r_drop <= r_outst - CW'(w_rsp);
      else if (w_rsp && (r_drop != '0))
        r_drop <= r_drop - CW'(1);

      if (w_redirect)
        r_fetch_pc <= w_jmp_tgt;
      else if (w_grant)
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);

      // Flushing clears every surviving tag; the responses they stood for are now counted in r_drop.
      if (w_redirect) begin
        r_tag_rd  <= r_tag_wr;
        r_out_rd  <= r_out_wr;
        r_out_cnt <= '0;
      end else begin
        if (w_grant) r_tag_wr <= r_tag_wr + PW'(1);
        if (w_keep)  r_tag_rd <= r_tag_rd + PW'(1);
        if (w_push)  r_out_wr <= r_out_wr + PW'(1);
        if (w_pop)   r_out_rd <= r_out_rd + PW'(1);
        r_out_cnt <= r_out_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant)
      r_tag[r_tag_wr] <= r_fetch_pc;
    if (w_push) begin
      r_out_pc[r_out_wr]  <= r_tag[r_tag_rd];
      r_out_ins[r_out_wr] <= imem_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_out_cnt == CW'(MAX_OUTST))));

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: queue-based reference model checked every cycle, plus hand-computed anchors.
module tb_if_fetch;
  localparam int          MAXO    = 4;
  localparam logic [31:0] RPC     = 32'h100;
  localparam logic [2:0]  HOLD_ID = 3'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        jmp_en_i;
  logic [31:0] jmp_to_i;
  logic [2:0]  hold_code_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  if_fetch #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(RPC), .MAX_OUTST(MAXO),
    .HOLD_W(3), .HOLD_CODE_ID(HOLD_ID)
  ) dut (
    .clk(clk), .rst(rst), .jmp_en_i(jmp_en_i), .jmp_to_i(jmp_to_i),
    .hold_code_i(hold_code_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Per-cycle stimulus, applied at the next negedge.
  logic        t_rst = 1'b1, t_jmp = 1'b0, t_gnt = 1'b1, t_frv = 1'b0;
  logic [31:0] t_to  = 32'd0;
  logic [2:0]  t_hc  = 3'd0;
  int          lat   = 1;

  logic [31:0] mq[$];
  int          mdue[$];

  // Reference model: in-flight fetches with a wrong-path flag, and the queue waiting for ID.
  bit          m_known = 1'b0;
  logic [31:0] m_fpc;
  logic [31:0] m_ipc[$];
  bit          m_idrop[$];
  logic [31:0] m_opc[$];
  logic [31:0] m_oins[$];

  bit          w_on = 1'b0;
  logic [31:0] w_exp;
  int          w_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic arm(input logic [31:0] pc);
    w_on   = 1'b1;
    w_exp  = pc;
    w_left = 12;
  endtask

  task automatic cycle();
    bit          hold, redir, e_req, e_vld, d;
    logic [31:0] e_pc, e_ins, p;
    @(negedge clk);
    cyc++;
    rst         = t_rst;
    jmp_en_i    = t_jmp;
    jmp_to_i    = t_to;
    hold_code_i = t_hc;
    imem_gnt_i  = t_gnt;
    if (t_rst) begin
      mq.delete();
      mdue.delete();
    end
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'd0;
    if (mq.size() > 0 && mdue[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mq[0] ^ 32'hA5;
      void'(mq.pop_front());
      void'(mdue.pop_front());
    end else if (t_frv) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
    #1;
    hold  = (t_hc == HOLD_ID);
    redir = t_jmp && !hold;
    e_req = !t_rst && (m_ipc.size() + m_opc.size() < MAXO) && !redir;
    e_vld = (m_opc.size() > 0);
    e_pc  = e_vld ? m_opc[0]  : 32'd0;
    e_ins = e_vld ? m_oins[0] : 32'd0;
    if (m_known) begin
      chk("req", 32'(imem_req_o), 32'(e_req));
      if (e_req) chk("addr", imem_addr_o, m_fpc);
      chk("valid", 32'(instr_valid_o), 32'(e_vld));
      chk("pc", pc_o, e_pc);
      chk("instr", instr_o, e_ins);
    end
    if (w_on) begin
      if (instr_valid_o === 1'b1) begin
        chk("first_pc_after_redirect", pc_o, w_exp);
        w_on = 1'b0;
      end else begin
        w_left--;
        if (w_left == 0) begin
          checks++;
          errors++;
          $display("FAIL first_pc_after_redirect: nothing valid within budget, expected pc %h", w_exp);
          w_on = 1'b0;
        end
      end
    end
    if (imem_req_o === 1'b1 && imem_gnt_i) begin
      mq.push_back(imem_addr_o);
      mdue.push_back(cyc + lat);
    end
    if (t_rst) begin
      m_fpc = RPC;
      m_ipc.delete(); m_idrop.delete(); m_opc.delete(); m_oins.delete();
      m_known = 1'b1;
    end else if (m_known) begin
      if (e_vld && !hold) begin
        void'(m_opc.pop_front());
        void'(m_oins.pop_front());
      end
      if (imem_rvalid_i && m_ipc.size() > 0) begin
        p = m_ipc.pop_front();
        d = m_idrop.pop_front();
        if (!d) begin
          m_opc.push_back(p);
          m_oins.push_back(imem_rdata_i);
        end
      end
      if (redir) begin
        foreach (m_idrop[i]) m_idrop[i] = 1'b1;
        m_opc.delete(); m_oins.delete();
        m_fpc = t_to & ~32'd3;
      end
      if (e_req && t_gnt) begin
        m_ipc.push_back(m_fpc);
        m_idrop.push_back(1'b0);
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic wait_two_inflight();
    for (int i = 0; i < 20; i++) begin
      if (m_ipc.size() == 2) break;
      cycle();
    end
    chk("two_inflight", 32'(m_ipc.size()), 32'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; jmp_en_i = 1'b0; jmp_to_i = 32'd0; hold_code_i = 3'd0;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;

    // Reset, then a stream from 0x100 with 1-cycle memory.
    repeat (3) cycle();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    t_rst = 1'b0;
    cycle();
    chk("start_req", 32'(imem_req_o), 32'd1);
    chk("start_addr", imem_addr_o, 32'h100);
    cycle();
    chk("start_valid_low", 32'(instr_valid_o), 32'd0);
    cycle();
    chk("stream_pc0", pc_o, 32'h100);
    chk("stream_instr0", instr_o, 32'h1A5);
    cycle();
    chk("stream_pc1", pc_o, 32'h104);

    // Hold for three cycles on 0x108; credits run out on the third.
    t_hc = HOLD_ID;
    cycle();
    chk("hold_pc_a", pc_o, 32'h108);
    cycle();
    chk("hold_pc_b", pc_o, 32'h108);
    cycle();
    chk("hold_pc_c", pc_o, 32'h108);
    chk("hold_req_off", 32'(imem_req_o), 32'd0);
    t_hc = 3'd2;
    cycle();
    cycle();
    chk("resume_pc", pc_o, 32'h10C);

    // Redirect to 0x2003 with two fetches in flight on 2-cycle memory.
    lat = 2;
    wait_two_inflight();
    t_jmp = 1'b1; t_to = 32'h2003;
    cycle();
    t_jmp = 1'b0;
    arm(32'h2000);
    cycle();
    chk("jmp_valid_n1", 32'(instr_valid_o), 32'd0);
    chk("jmp_req_n1", 32'(imem_req_o), 32'd1);
    chk("jmp_addr_n1", imem_addr_o, 32'h2000);
    repeat (8) cycle();

    // Jump under hold is ignored; taken the next cycle.
    lat = 1;
    t_hc = HOLD_ID; t_jmp = 1'b1; t_to = 32'h3000;
    cycle();
    t_hc = 3'd0;
    cycle();
    chk("jmp_taken_req_off", 32'(imem_req_o), 32'd0);
    t_jmp = 1'b0;
    arm(32'h3000);
    cycle();
    chk("jmp_after_hold_addr", imem_addr_o, 32'h3000);
    repeat (6) cycle();

    // Grant stall at the top of the address space, then wrap.
    t_jmp = 1'b1; t_to = 32'hFFFF_FFFC; t_gnt = 1'b0;
    cycle();
    t_jmp = 1'b0;
    arm(32'hFFFF_FFFC);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("stall_req", 32'(imem_req_o), 32'd1);
      chk("stall_addr", imem_addr_o, 32'hFFFF_FFFC);
    end
    t_gnt = 1'b1;
    cycle();
    cycle();
    chk("wrap_addr", imem_addr_o, 32'h0);
    repeat (4) cycle();

    // Reset with two fetches outstanding, then a stray response.
    lat = 2;
    wait_two_inflight();
    t_rst = 1'b1;
    cycle();
    t_rst = 1'b0; t_frv = 1'b1;
    arm(32'h100);
    cycle();
    t_frv = 1'b0;
    chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("mid_rst_pc", pc_o, 32'd0);
    chk("mid_rst_instr", instr_o, 32'd0);
    chk("mid_rst_req", 32'(imem_req_o), 32'd1);
    chk("mid_rst_addr", imem_addr_o, 32'h100);
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch front end of the pipeline. It owns the program counter, issues fetches to instruction memory, buffers returned instructions and hands them to ID in order. It consumes the redirect and stall outputs of the branch/hazard control unit (`jmp_en`, `jmp_to`, `hold_code`): branches and jumps redirect the PC, and load-use holds freeze delivery to ID. Instructions fetched down a wrong path are discarded so they never reach ID.

## Interface

Parameters:
- `ADDR_W`, default 32: PC / memory address width.
- `INSTR_W`, default 32: instruction width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `MAX_OUTST`, default 2: maximum in-flight plus buffered fetches. Legal values are 2 and 4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `jmp_en_i`  in  1  redirect request from control; 1 = take the branch or jump.
- `jmp_to_i`  in  ADDR_W  redirect target.
- `hold_code_i`  in  `BUS_HOLD_CODE`  stall code from control. Hold is active when it equals `HOLD_CODE_ID`.
- `imem_req_o`  out  1  fetch request.
- `imem_addr_o`  out  ADDR_W  fetch address; word-aligned.
- `imem_gnt_i`  in  1  request accepted this cycle when high together with `imem_req_o`.
- `imem_rvalid_i`  in  1  response valid. Responses arrive in order, at least 1 cycle after the grant.
- `imem_rdata_i`  in  INSTR_W  response instruction.
- `instr_valid_o`  out  1  `instr_o` / `pc_o` hold a valid instruction for ID.
- `instr_o`  out  INSTR_W  instruction to ID.
- `pc_o`  out  ADDR_W  PC of `instr_o`.

## Operation

- **State:**
  - `fetch_pc`: next address to request.
  - `outst` counter: granted requests with no response yet.
  - `drop` counter: in-flight responses to discard.
  - FIFO of {pc, instr}, depth MAX_OUTST.
  - A pc-tag FIFO records the address of each granted request, in order.
- **Issue:**
  - `imem_req_o` = !rst && (outst + fifo_count < MAX_OUTST) && !redirect.
  - `imem_addr_o` = `fetch_pc`.
  - On grant: `fetch_pc` += 4, outst += 1, and the address is pushed onto the pc-tag FIFO.
- **Response:**
  - On `imem_rvalid_i`, outst -= 1 and the head tag is popped.
  - If drop > 0: drop -= 1 and the data is discarded.
  - Otherwise {tag, rdata} is pushed to the output FIFO.
  - The credit rule guarantees the FIFO cannot overflow. A push into a full FIFO is a design error; it is flagged by an assertion.
- **Delivery to ID:**
  - `instr_valid_o` = FIFO non-empty; `instr_o` / `pc_o` = FIFO head.
  - The head is popped when valid and hold is inactive.
  - While hold is active the outputs are stable and nothing is popped.
- **Redirect** (redirect = `jmp_en_i` && !hold):
  - `fetch_pc` ← `jmp_to_i` & ~3.
  - The output FIFO and pc-tag entries are flushed.
  - drop ← outst − (response this cycle ? 1 : 0).
  - No request is issued in the redirect cycle.
  - Redirect and delivery pop in the same cycle are allowed: the instruction leaving this cycle is the branch itself and is consumed; everything younger is flushed.
- **Hold wins over jump:** when hold is active, `jmp_en_i` is ignored. Control re-evaluates the branch in the next cycle with forwarded data.
- **Address arithmetic:** `fetch_pc` is modulo 2^ADDR_W, so 32'hFFFF_FFFC + 4 wraps to 0.

## Timing

- **Reset** (synchronous; `rst` high at an edge):
  - `fetch_pc` = RESET_PC; outst = drop = 0; FIFOs empty.
  - `imem_req_o` = 0, `instr_valid_o` = 0, `instr_o` = 0, `pc_o` = 0.
  - Responses arriving during reset are ignored.
- **Startup:** in the first cycle after `rst` falls, `imem_req_o` = 1 and `imem_addr_o` = RESET_PC.
- **Latency:**
  - The output FIFO is registered.
  - A response accepted at edge N drives `instr_valid_o` in the cycle after edge N.
  - With 1-cycle memory and no stalls, throughput is 1 instruction per cycle.
- **Redirect:**
  - Redirect asserted in cycle N; the first request to `jmp_to_i` goes out in cycle N+1.
  - `instr_valid_o` = 0 from cycle N+1 until the new-path data returns.
- **Reset mid-operation:** all in-flight responses are dropped. drop is cleared and not reloaded, because the memory must also be reset.
- **Back-pressure:** with a full FIFO and hold active, `imem_req_o` stays low. The memory may hold `imem_gnt_i` low indefinitely; requests stay asserted with a stable address.

## Test plan

- **Reset and stream:** RESET_PC=0x100, 1-cycle memory returning addr^0xA5 → pc_o = 0x100, 0x104, 0x108… on consecutive cycles, starting 2 cycles after `rst` falls.
- **Branch redirect:** `jmp_en_i`=1, `jmp_to_i`=0x2003 while 2 requests are in flight → both stale responses dropped; next pc_o = 0x2000; no 0x10C-path instruction is ever valid.
- **Hold:** `hold_code_i`=`HOLD_CODE_ID` for 3 cycles with pc_o=0x108 valid → outputs unchanged for 3 cycles; req deasserts once outst+fifo=MAX_OUTST; resumes with 0x10C.
- **Hold with jump:** `jmp_en_i`=1 and hold both active → no redirect. Next cycle, hold low and jmp_en high → redirect taken.
- **Grant stall and wrap:** `fetch_pc`=0xFFFF_FFFC, `imem_gnt_i` low for 4 cycles → `imem_addr_o` stable at 0xFFFF_FFFC. After the grant, next address = 0x0000_0000.
- **Reset mid-fetch:** `rst` pulsed with 2 requests outstanding → all outputs 0 next cycle; a late rvalid is ignored; fetch restarts at RESET_PC.
